// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: synchronizes the PS/2 pins, deframes scan-code
// bytes, folds E0/F0 prefixes into flags and queues codes in a show-ahead FIFO.
module ps2_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rx_en,
    input  logic                          pop,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic [9:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [9:0]      shift_q, shift_d;
    logic            clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [9:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d, busy_q, busy_d;
    logic            par_err_q, par_err_d, frm_err_q, frm_err_d, ovf_q, ovf_d;

    logic            fall_c, par_ev_c, frm_ev_c, byte_vld_c, push_req_c;
    logic            do_push_c, do_pop_c, full_c, ovf_ev_c;
    logic [9:0]      entry_c;

    assign fall_c = clk_prev_q & ~clk_s2_q;

    // Pin synchronizers and edge detector idle high so reset release is edge-free
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame FSM: shift register fills LSB-first so data/parity/stop land in [7:0]/[8]/[9]
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_d      = tmo_q;
        shift_d    = shift_q;
        par_ev_c   = 1'b0;
        frm_ev_c   = 1'b0;
        byte_vld_c = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                if (rx_en && fall_c && !dat_s2_q) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end else if (fall_c) begin
                    shift_d   = {dat_s2_q, shift_q[9:1]};
                    tmo_d     = '0;
                    bit_cnt_d = 4'(bit_cnt_q + 4'd1);
                    if (bit_cnt_q == 4'd10) state_d = CHECK;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    frm_ev_c  = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = TW'(tmo_q + TW'(1));
                end
            end
            CHECK: begin
                par_ev_c   = ~(^shift_q[8:0]);
                frm_ev_c   = ~shift_q[9];
                byte_vld_c = ~par_ev_c & ~frm_ev_c;
                state_d    = IDLE;
                bit_cnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Prefix decoder
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        push_req_c = 1'b0;
        entry_c    = {ext_q, brk_q, shift_q[7:0]};
        if (byte_vld_c) begin
            if (shift_q[7:0] == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q[7:0] == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_req_c = 1'b1;
                ext_d      = 1'b0;
                brk_d      = 1'b0;
            end
        end
        if (par_ev_c || frm_ev_c || flush) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    // Show-ahead FIFO; head is re-registered from the next-state array
    always_comb begin
        full_c    = (count_q == CW'(FIFO_DEPTH));
        do_pop_c  = pop && (count_q != '0) && !flush;
        do_push_c = push_req_c && !flush && (!full_c || do_pop_c);
        ovf_ev_c  = push_req_c && !flush && full_c && !pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = entry_c;
                wr_ptr_d        = PW'(wr_ptr_q + PW'(1));
            end
            if (do_pop_c) rd_ptr_d = PW'(rd_ptr_q + PW'(1));
            if (do_push_c && !do_pop_c) count_d = CW'(count_q + CW'(1));
            if (!do_push_c && do_pop_c) count_d = CW'(count_q - CW'(1));
        end
        rd_valid_d = (count_d != '0);
        rd_data_d  = rd_valid_d ? mem_d[rd_ptr_d] : '0;
        busy_d     = (state_d != IDLE);
        par_err_d  = (clr_err ? 1'b0 : par_err_q) | par_ev_c;
        frm_err_d  = (clr_err ? 1'b0 : frm_err_q) | frm_ev_c;
        ovf_d      = (clr_err ? 1'b0 : ovf_q) | ovf_ev_c;
    end

    always_ff @(posedge ACLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            shift_q    <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_q      <= tmo_d;
            shift_q    <= shift_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign parity_err = par_err_q;
    assign frame_err  = frm_err_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: drives PS/2 frames on the pins and checks
// the FIFO head, count, busy and sticky error flags against hand-computed values.
module tb_ps2_rx_ctrl;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 200;

    logic       ACLK, ARESET, ps2_clk, ps2_data, rx_en, pop, flush, clr_err;
    logic [9:0] rd_data;
    logic       rd_valid, busy, parity_err, frame_err, overflow;
    logic [3:0] fifo_count;
    int         vecs  = 0;
    int         fails = 0;

    ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_en(rx_en), .pop(pop), .flush(flush), .clr_err(clr_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .busy(busy), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // One PS/2 bit: data set, clock low for 4 cycles, back high; ends at posedge+1
    task automatic ps2_bit(input logic b);
        @(posedge ACLK); #1 ps2_data = b;
        repeat (4) @(posedge ACLK); #1 ps2_clk = 1'b0;
        repeat (4) @(posedge ACLK); #1 ps2_clk = 1'b1;
    endtask

    // Start..parity, then drops the clock for the stop bit and returns at posedge+1
    task automatic frame_head(input logic [7:0] b, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        @(posedge ACLK); #1 ps2_data = stop;
        repeat (4) @(posedge ACLK); #1 ps2_clk = 1'b0;
    endtask

    task automatic frame_tail();
        repeat (4) @(posedge ACLK); #1 ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (6) @(posedge ACLK); #1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        frame_head(b, ~^b, 1'b1);
        frame_tail();
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n - 1; i++) ps2_bit(b[i]);
    endtask

    task automatic pop_one();
        pop = 1'b1; @(posedge ACLK); #1 pop = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1; @(posedge ACLK); #1 clr_err = 1'b0;
    endtask

    task automatic test_reset();
        vecs++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        vecs++; if (rd_data !== 10'h000) begin fails++; $display("FAIL reset_data: got %h want 000", rd_data); end
        vecs++; if (fifo_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if ({parity_err, frame_err, overflow} !== 3'b000) begin fails++; $display("FAIL reset_errs: got %b want 000", {parity_err, frame_err, overflow}); end
    endtask

    task automatic test_single();
        frame_head(8'h1C, 1'b0, 1'b1);
        vecs++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (3) @(posedge ACLK); #1;
        vecs++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b want 0", rd_valid); end
        @(posedge ACLK); #1;
        vecs++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", rd_valid); end
        vecs++; if (rd_data !== 10'h01C) begin fails++; $display("FAIL single_data: got %h want 01C", rd_data); end
        vecs++; if (fifo_count !== 4'd1) begin fails++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        frame_tail();
        pop_one();
        vecs++; if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin fails++; $display("FAIL single_pop: got valid %b count %0d want 0 0", rd_valid, fifo_count); end
    endtask

    task automatic test_prefix();
        send_frame(8'hE0);
        send_frame(8'hF0);
        vecs++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL prefix_nopush: got %b want 0", rd_valid); end
        send_frame(8'h74);
        vecs++; if (rd_data !== 10'h374) begin fails++; $display("FAIL prefix_data: got %h want 374", rd_data); end
        vecs++; if (fifo_count !== 4'd1) begin fails++; $display("FAIL prefix_count: got %0d want 1", fifo_count); end
        pop_one();
        send_frame(8'h74);
        vecs++; if (rd_data !== 10'h074) begin fails++; $display("FAIL prefix_cleared: got %h want 074", rd_data); end
        pop_one();
    endtask

    task automatic test_errors();
        send_frame(8'hE0);
        frame_head(8'h1C, 1'b1, 1'b1);
        frame_tail();
        vecs++; if (parity_err !== 1'b1) begin fails++; $display("FAIL parity_set: got %b want 1", parity_err); end
        vecs++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL parity_nopush: got %b want 0", rd_valid); end
        clr_pulse();
        vecs++; if (parity_err !== 1'b0) begin fails++; $display("FAIL parity_clr: got %b want 0", parity_err); end
        send_frame(8'h1C);
        vecs++; if (rd_data !== 10'h01C) begin fails++; $display("FAIL parity_prefix_drop: got %h want 01C", rd_data); end
        pop_one();
        frame_head(8'h1C, 1'b0, 1'b0);
        frame_tail();
        vecs++; if (frame_err !== 1'b1 || rd_valid !== 1'b0) begin fails++; $display("FAIL stop_err: got err %b valid %b want 1 0", frame_err, rd_valid); end
        clr_pulse();
    endtask

    task automatic test_timeout();
        send_partial(8'h1C, 5);
        vecs++; if (busy !== 1'b1) begin fails++; $display("FAIL tmo_busy_mid: got %b want 1", busy); end
        repeat (TMO + 20) @(posedge ACLK); #1;
        vecs++; if (frame_err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b want 1", frame_err); end
        vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy: got %b want 0", busy); end
        send_frame(8'h1C);
        vecs++; if (rd_data !== 10'h01C || fifo_count !== 4'd1) begin fails++; $display("FAIL tmo_recover: got %h cnt %0d want 01C 1", rd_data, fifo_count); end
        pop_one();
        clr_pulse();
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        for (int i = 1; i <= 9; i++) send_frame(8'(i));
        vecs++; if (fifo_count !== 4'd8) begin fails++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
        vecs++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        vecs++; if (rd_data !== 10'h001) begin fails++; $display("FAIL ovf_head: got %h want 001", rd_data); end
        clr_pulse();
        frame_head(8'h0A, ~^8'h0A, 1'b1);
        repeat (3) @(posedge ACLK); #1 pop = 1'b1;
        @(posedge ACLK); #1 pop = 1'b0;
        vecs++; if (fifo_count !== 4'd8) begin fails++; $display("FAIL pushpop_count: got %0d want 8", fifo_count); end
        vecs++; if (overflow !== 1'b0) begin fails++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
        frame_tail();
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 10'(i + 2) : 10'h00A;
            vecs++; if (rd_data !== exp) begin fails++; $display("FAIL drain_%0d: got %h want %h", i, rd_data, exp); end
            pop_one();
        end
        vecs++; if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin fails++; $display("FAIL drain_empty: got valid %b cnt %0d want 0 0", rd_valid, fifo_count); end
        pop_one();
        vecs++; if (fifo_count !== 4'd0) begin fails++; $display("FAIL pop_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_flush();
        send_frame(8'h1C);
        send_frame(8'h2C);
        send_frame(8'hE0);
        flush = 1'b1; @(posedge ACLK); #1 flush = 1'b0;
        vecs++; if (rd_valid !== 1'b0 || fifo_count !== 4'd0) begin fails++; $display("FAIL flush_empty: got valid %b cnt %0d want 0 0", rd_valid, fifo_count); end
        send_frame(8'h74);
        vecs++; if (rd_data !== 10'h074) begin fails++; $display("FAIL flush_prefix: got %h want 074", rd_data); end
        pop_one();
    endtask

    task automatic test_rx_en();
        send_partial(8'h33, 4);
        rx_en = 1'b0;
        repeat (3) @(posedge ACLK); #1;
        vecs++; if (busy !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rxen_abort: got busy %b ferr %b want 0 0", busy, frame_err); end
        send_frame(8'h1C);
        vecs++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rxen_off: got %b want 0", rd_valid); end
        rx_en = 1'b1;
        send_frame(8'h29);
        vecs++; if (rd_data !== 10'h029 || fifo_count !== 4'd1) begin fails++; $display("FAIL rxen_resume: got %h cnt %0d want 029 1", rd_data, fifo_count); end
        pop_one();
    endtask

    task automatic test_areset();
        send_frame(8'h1C);
        frame_head(8'h1C, 1'b1, 1'b1);
        frame_tail();
        send_partial(8'h5A, 4);
        #3 ARESET = 1'b1;
        #1;
        vecs++; if ({rd_valid, fifo_count, rd_data} !== 15'h0) begin fails++; $display("FAIL arst_fifo: got valid %b cnt %0d data %h want 0", rd_valid, fifo_count, rd_data); end
        vecs++; if ({busy, parity_err, frame_err, overflow} !== 4'b0000) begin fails++; $display("FAIL arst_flags: got %b want 0000", {busy, parity_err, frame_err, overflow}); end
        @(posedge ACLK); #1 ARESET = 1'b0;
        send_frame(8'h5A);
        vecs++; if (rd_data !== 10'h05A || fifo_count !== 4'd1) begin fails++; $display("FAIL arst_next: got %h cnt %0d want 05A 1", rd_data, fifo_count); end
    endtask

    initial begin
        ARESET = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        rx_en = 1'b1; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge ACLK); #1;
        test_reset();
        ARESET = 1'b0;
        repeat (3) @(posedge ACLK); #1;
        test_single();
        test_prefix();
        test_errors();
        test_timeout();
        test_overflow();
        test_flush();
        test_rx_en();
        test_areset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameters: FIFO_DEPTH, default 8, scan-code FIFO entries (power of 2); TIMEOUT_CYCLES, default 100000, max ACLK cycles between PS/2 clock falling edges inside a frame.
REQ-002 ACLK  in  1  single system clock; all state rises on ACLK.
REQ-003 ARESET  in  1  asynchronous, active-high reset.
REQ-004 ps2_clk  in  1  raw PS/2 clock pin, asynchronous to ACLK.
REQ-005 ps2_data  in  1  raw PS/2 data pin, asynchronous to ACLK.
REQ-006 rx_en  in  1  reception enable.
REQ-007 pop  in  1  consume FIFO head.
REQ-008 flush  in  1  empty FIFO and clear prefix state.
REQ-009 clr_err  in  1  clear sticky error flags.
REQ-010 rd_data  out  10  FIFO head {ext, brk, code[7:0]}.
REQ-011 rd_valid  out  1  FIFO non-empty.
REQ-012 fifo_count  out  clog2(FIFO_DEPTH)+1  entries held.
REQ-013 busy  out  1  frame FSM not IDLE.
REQ-014 parity_err, frame_err, overflow  out  1 each  sticky error flags.

Function
REQ-015 ps2_clk and ps2_data each pass a 2-FF synchronizer; falling edge = previous synced clk 1, current 0; data sampled from synced data in the edge cycle.
REQ-016 Frame FSM states IDLE, RECV, CHECK.
REQ-017 IDLE: rx_en=1 and falling edge with data 0 -> RECV, bit_cnt=1; edge with data 1 ignored, no error.
REQ-018 RECV: each falling edge captures one bit, LSB first: bits 1-8 data, 9 parity, 10 stop; after stop bit -> CHECK.
REQ-019 CHECK (one cycle): odd parity required (XOR of 8 data bits and parity = 1) else parity_err set; stop=0 sets frame_err; valid byte passed to decoder; -> IDLE.
REQ-020 Timeout counter resets on every falling edge in RECV; reaching TIMEOUT_CYCLES sets frame_err, discards partial frame, -> IDLE.
REQ-021 rx_en deasserted in RECV: abort to IDLE, discard partial frame, no error.
REQ-022 Decoder: byte 0xE0 sets ext_pend, 0xF0 sets brk_pend, no push; any other byte pushes {ext_pend, brk_pend, byte} and clears both.
REQ-023 Any parity or frame error clears ext_pend and brk_pend.
REQ-024 Latency: entry visible on rd_data/rd_valid exactly 2 ACLK cycles after the cycle in which the stop-bit edge is detected (FIFO previously empty).
REQ-025 FIFO is show-ahead; pop with rd_valid=1 advances head next cycle; pop when empty ignored.
REQ-026 Push when full without pop: entry dropped, contents unchanged, overflow set.
REQ-027 Push and pop same cycle when full: both performed, count unchanged, no overflow.
REQ-028 flush has priority: FIFO emptied, prefix flags cleared, simultaneous push discarded; error flags unaffected.
REQ-029 clr_err clears all three error flags; an error event in the same cycle wins (flag remains 1).
REQ-030 Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.

Reset
REQ-031 ARESET forces FSM IDLE, bit_cnt and timeout 0, FIFO empty, prefix flags 0, all outputs 0, immediately and asynchronously.
REQ-032 Synchronizer and edge-detect flops reset to 1 (idle line) so release produces no false edge.
REQ-033 ARESET mid-frame discards the partial frame; next full frame is received normally.

Verification
REQ-034 Frame 0x1C, parity 0, stop 1 -> rd_valid=1, rd_data=0x01C, fifo_count=1, 2 cycles after stop edge.
REQ-035 Frames 0xE0, 0xF0, 0x74 -> one entry rd_data=0x374, fifo_count=1.
REQ-036 Frame 0x1C with parity 1 -> parity_err=1, no entry; clr_err pulse -> parity_err=0.
REQ-037 Clock stopped after 5 bits for TIMEOUT_CYCLES -> frame_err=1, busy=0; following good 0x1C frame -> rd_data=0x01C.
REQ-038 Nine frames 0x01..0x09, no pop, depth 8 -> fifo_count=8, overflow=1, rd_data=0x001; pop and push in same cycle at full -> fifo_count=8, overflow unchanged.
REQ-039 ARESET asserted after 4 bits of a frame -> all outputs 0, busy=0; subsequent frame 0x5A -> rd_data=0x05A.
